// File: rtl/cvita_insert_tlast_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cvita_insert_tlast_pkg
// Purpose : Shared CVITA constants and helpers. It holds the header
//           length-field position, the bytes-per-word shift, and the
//           byte-length to word-count conversion.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package cvita_insert_tlast_pkg;

    localparam int c_data_w    = 64;
    localparam int c_len_hi    = 47;   // header packet-length field, bytes
    localparam int c_len_lo    = 32;
    localparam int c_word_shft = 3;    // 8 bytes per 64-bit word
    localparam int c_count_w   = 16 - c_word_shft;

    // Convert a byte length to a word count: ceil(len/8).
    // A zero-length packet still occupies its header word, so it counts as 1.
    // The result is one bit wider than the counter because ceil(65535/8)
    // is 8192.
    function automatic logic [c_count_w:0] words_of(input logic [15:0] len);
        logic [c_count_w:0] w;
        w = {1'b0, len[15:c_word_shft]} +
            {{c_count_w{1'b0}}, |len[c_word_shft-1:0]};
        if (w == '0) begin
            w = {{c_count_w{1'b0}}, 1'b1};
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cvita_insert_tlast.sv
`default_nettype none
// ============================================================================
// Module  : cvita_insert_tlast
// Purpose : Regenerates tlast on a CVITA stream from the header length field.
//           Data, valid and ready pass straight through with no added latency.
// Ports   : clk        - clock, rising edge
//           reset      - asynchronous reset, active low
//           clear      - synchronous state clear, active high
//           i_tdata    - input beat data [63:0]; the first beat of a packet
//                        is the header
//           i_tvalid   - input beat valid
//           i_tready   - input ready (equal to o_tready)
//           o_tdata    - output data (equal to i_tdata)
//           o_tlast    - regenerated end-of-packet flag
//           o_tvalid   - output valid (equal to i_tvalid)
//           o_tready   - downstream ready
// Rev     : 1.0 - initial release
// ============================================================================
module cvita_insert_tlast
    import cvita_insert_tlast_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [c_data_w-1:0] i_tdata,
    input  logic                i_tvalid,
    output logic                i_tready,
    output logic [c_data_w-1:0] o_tdata,
    output logic                o_tlast,
    output logic                o_tvalid,
    input  logic                o_tready
);

    logic                 r_sop;
    logic [c_count_w-1:0] r_count;

    logic [15:0]          w_len;
    logic [c_count_w:0]   w_words;
    logic                 w_hdr_last;
    logic                 w_xfer;
    logic                 w_last;

    assign o_tdata  = i_tdata;
    assign o_tvalid = i_tvalid;
    assign i_tready = o_tready;

    assign w_len      = i_tdata[c_len_hi:c_len_lo];
    assign w_words    = words_of(w_len);
    assign w_hdr_last = (w_words <= {{c_count_w{1'b0}}, 1'b1});
    assign w_xfer     = i_tvalid & o_tready;
    assign w_last     = r_sop ? w_hdr_last
                              : (r_count == {{(c_count_w-1){1'b0}}, 1'b1});
    assign o_tlast    = w_last;

    // The end of a packet always re-arms sop. The count is also zeroed there,
    // so the state after any packet matches the reset state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sop   <= 1'b1;
            r_count <= '0;
        end else if (clear) begin
            r_sop   <= 1'b1;
            r_count <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                r_sop   <= 1'b1;
                r_count <= '0;
            end else if (r_sop) begin
                // w_words > 1 on this path, so w_words-1 fits the counter.
                r_sop   <= 1'b0;
                r_count <= w_words[c_count_w-1:0] - 1'b1;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cvita_insert_tlast.sv
`default_nettype none
// ============================================================================
// Module  : tb_cvita_insert_tlast
// Purpose : Directed self-checking bench for cvita_insert_tlast.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_cvita_insert_tlast;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [63:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    int errors = 0;
    int checks = 0;

    // Payload beats have all ones in the length-field bits, so a design that
    // decodes length on a non-header beat gets the wrong tlast.
    localparam logic [63:0] c_body = 64'hFFFF_FFFF_FFFF_FFFF;

    cvita_insert_tlast dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [15:0] len);
        return {16'h1234, len, 32'hA5A5_0000};
    endfunction

    task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle and check tlast and the pass-through paths mid-cycle.
    // Afterwards, advance to just after the next rising edge.
    task automatic beat(input logic [63:0] d, input logic v, input logic rdy,
                        input logic clr, input logic exp_last, input string tag);
        i_tdata  = d;
        i_tvalid = v;
        o_tready = rdy;
        clear    = clr;
        @(negedge clk);
        check_val({tag, "_last"}, {71'd0, o_tlast}, {71'd0, exp_last});
        check_val({tag, "_pass"}, {6'd0, o_tdata, o_tvalid, i_tready}, {6'd0, d, v, rdy});
        @(posedge clk);
        #1;
    endtask

    int lens  [9] = '{24, 20, 16, 12, 8, 4, 4, 8, 12};
    int words [9] = '{ 3,  3,  2,  2, 1, 1, 1, 1,  2};

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        i_tdata  = hdr(16'd24);
        i_tvalid = 1'b1;
        o_tready = 1'b1;

        // Held in reset: a header decode with sop=1 and no state change across edges.
        #1;
        check_val("rst_len24", {71'd0, o_tlast}, 72'd0);
        @(posedge clk); #1;
        i_tdata = hdr(16'd8);
        #1;
        check_val("rst_len8", {71'd0, o_tlast}, 72'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        // len=24 then 2 more beats.
        beat(hdr(16'd24), 1, 1, 0, 0, "p24_h");
        beat(c_body,      1, 1, 0, 0, "p24_b1");
        beat(c_body,      1, 1, 0, 1, "p24_b2");

        // Single-beat packets.
        beat(hdr(16'd8), 1, 1, 0, 1, "s8");
        beat(hdr(16'd4), 1, 1, 0, 1, "s4a");
        beat(hdr(16'd4), 1, 1, 0, 1, "s4b");

        // Length boundaries: 0 acts as 1 word, 9 needs 2 words.
        beat(hdr(16'd0), 1, 1, 0, 1, "len0");
        beat(hdr(16'd9), 1, 1, 0, 0, "len9_h");
        beat(c_body,     1, 1, 0, 1, "len9_b");

        // Back-to-back sequence.
        foreach (lens[i]) begin
            for (int w = 0; w < words[i]; w++) begin
                beat((w == 0) ? hdr(16'(lens[i])) : c_body, 1, 1, 0,
                     (w == words[i] - 1), $sformatf("seq%0d_w%0d", i, w));
            end
        end

        // len=20 with ready toggling; tlast holds while stalled.
        beat(hdr(16'd20), 1, 0, 0, 0, "stl_h_s");
        beat(hdr(16'd20), 1, 1, 0, 0, "stl_h");
        beat(c_body,      1, 0, 0, 0, "stl_b1_s");
        beat(c_body,      1, 1, 0, 0, "stl_b1");
        beat(c_body,      1, 0, 0, 1, "stl_b2_s");
        beat(c_body,      1, 1, 0, 1, "stl_b2");

        // Valid low holds state mid-packet.
        beat(hdr(16'd24), 1, 1, 0, 0, "vld_h");
        beat(c_body,      0, 1, 0, 0, "vld_idle");
        beat(c_body,      1, 1, 0, 0, "vld_b1");
        beat(c_body,      1, 1, 0, 1, "vld_b2");

        // Clear after the first beat overrides a simultaneous transfer.
        beat(hdr(16'd24), 1, 1, 0, 0, "clr_h");
        beat(c_body,      1, 1, 1, 0, "clr_b");
        beat(hdr(16'd8),  1, 1, 0, 1, "clr_next");

        // Async reset pulse mid-packet.
        beat(hdr(16'd24), 1, 1, 0, 0, "ar_h");
        reset = 1'b0;
        #2;
        reset = 1'b1;
        beat(hdr(16'd8),  1, 1, 0, 1, "ar_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cvita_insert_tlast.md
CVITA_INSERT_TLAST -- requirements
Module: cvita_insert_tlast

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 64 bits.
REQ-002 Port `clk`: input, 1 bit; the single clock, all state is rising-edge triggered.
REQ-003 Port `reset`: input, 1 bit; asynchronous, active-low reset.
REQ-004 Port `clear`: input, 1 bit; synchronous, active-high state clear.
REQ-005 Port `i_tdata`: input, 64 bits; CVITA stream data in; the first beat of each packet is the header.
REQ-006 Port `i_tvalid`: input, 1 bit; input beat valid.
REQ-007 Port `i_tready`: output, 1 bit; input beat accepted.
REQ-008 Port `o_tdata`: output, 64 bits; stream data out.
REQ-009 Port `o_tlast`: output, 1 bit; regenerated end-of-packet flag.
REQ-010 Port `o_tvalid`: output, 1 bit; output beat valid.
REQ-011 Port `o_tready`: input, 1 bit; downstream ready.

Function
REQ-012 Data path SHALL be combinational pass-through with zero latency: o_tdata = i_tdata, o_tvalid = i_tvalid, i_tready = o_tready.
REQ-013 A beat SHALL be transferred when i_tvalid and o_tready are both 1; state SHALL change only on a transfer or on clear/reset.
REQ-014 State SHALL be a start-of-packet flag `sop` and a 13-bit remaining-word counter `count`.
REQ-015 The packet length field SHALL be i_tdata[47:32], in bytes, sampled on the header beat (sop=1).
REQ-016 The word count SHALL be ceil(len/8), i.e. len[15:3] + (|len[2:0]); len=0 SHALL be treated as 1 word.
REQ-017 On the header beat, o_tlast SHALL be 1 iff the word count is at most 1 (len <= 8).
REQ-018 On the header beat with word count N > 1, a transfer SHALL load count = N-1 and clear sop.
REQ-019 On a non-header beat, o_tlast SHALL be 1 iff count == 1; a transfer SHALL decrement count.
REQ-020 Any transfer with o_tlast=1 SHALL set sop=1, so the next beat is treated as a header.
REQ-021 o_tlast SHALL be combinational from sop, count and i_tdata, and SHALL be valid whenever o_tvalid=1.
REQ-022 The input tlast is not a port; packet framing SHALL derive solely from the header length.
REQ-023 With o_tready=0, or i_tvalid=0, state SHALL hold and o_tlast SHALL remain stable for the held beat.
REQ-024 clear=1 at a clock edge SHALL force sop=1 and count=0, overriding any simultaneous transfer.
REQ-025 Back-to-back packets with no idle cycle SHALL be framed correctly.

Reset
REQ-026 While reset=0, sop SHALL be 1 and count SHALL be 0, asynchronously.
REQ-027 Outputs have no reset value of their own: o_tdata, o_tvalid and i_tready follow their inputs; o_tlast reflects sop=1.
REQ-028 Reset mid-packet SHALL abandon the packet; the next beat after reset deasserts is a header.

Structure
REQ-029 The CVITA length-field bit positions (47:32) and the bytes-per-word shift (3) SHALL be constants in the shared CVITA package.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 len=24 header, then 2 more beats, o_tready=1 -> o_tlast = 0,0,1.
REQ-032 Single-beat packets len=8, then len=4, then len=4 -> o_tlast=1 on each header.
REQ-033 Sequence len 24,20,16,12,8,4,4,8,12 sent back-to-back -> word counts 3,3,2,2,1,1,1,1,2, with o_tlast on each final beat only.
REQ-034 len=20 with o_tready toggled 0/1 every cycle -> o_tlast=1 only on the 3rd accepted beat, stable while stalled.
REQ-035 Assert clear (or reset) after the 1st beat of a len=24 packet -> the next beat is decoded as a header; len=8 there -> o_tlast=1.
